// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle RISC-V controller.
// RV_JAL_EN adds the JAL state to the state enum.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_TRAP     = 4'd10
`ifdef RV_JAL_EN
        , S_JAL    = 4'd11
`endif
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_sel = IMM_S;
            OP_BRANCH: imm_sel = IMM_B;
            OP_JAL:    imm_sel = IMM_J;
            default:   imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU operation decoder: maps the FSM's ALU-op class plus
// funct3/funct7b5 onto the 3-bit ALU code.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       is_rtype_i,
    output logic [2:0] alu_code_o
);

    // Subtract only for R-type funct3=000 with bit 30 set; addi never subtracts
    always_comb begin
        alu_code_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_code_o = ALU_ADD;
            ALUOP_SUB: alu_code_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_code_o = (funct7b5_i && is_rtype_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_code_o = ALU_SLT;
                    3'b110:  alu_code_o = ALU_OR;
                    3'b111:  alu_code_o = ALU_AND;
                    default: alu_code_o = ALU_ADD;
                endcase
            end
            default: alu_code_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle RISC-V control FSM with memory wait timeout and
// sticky trap flags. Define RV_JAL_EN to support JAL; otherwise it traps.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic                  adr_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [1:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal,
    output logic                  bus_err
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ill_q, ill_d;
    logic       be_q, be_d;
    logic       is_req_s, timeout_s, en_s;
    logic [1:0] alu_op_s;
    logic [2:0] alu_code_s;

    assign is_req_s  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timeout_s = ((cnt_q + 8'd1) == TIMEOUT_C);
    assign en_s      = rst_n;

    // State, wait counter and sticky flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= 8'd0;
            ill_q   <= 1'b0;
            be_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            be_q    <= be_d;
        end
    end

    // Next-state, wait counter and trap flag logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : (timeout_s ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BEQ;
`ifdef RV_JAL_EN
                    OP_JAL:            state_d = S_JAL;
`endif
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : (timeout_s ? S_TRAP : S_MEMREAD);
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : (timeout_s ? S_TRAP : S_MEMWRITE);
            S_EXEC_R:   state_d = S_ALUWB;
            S_EXEC_I:   state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
`ifdef RV_JAL_EN
            S_JAL:      state_d = S_ALUWB;
`endif
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase

        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if (is_req_s && !mem_ready) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        ill_d = ill_q | ((state_q == S_DECODE) && (state_d == S_TRAP));
        be_d  = be_q | (is_req_s && !mem_ready && timeout_s);
    end

    // Output decode; strobes are forced low while reset is asserted
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        alu_op_s   = ALUOP_ADD;
        imm_src    = imm_sel(op);
        case (state_q)
            S_FETCH: begin
                mem_req    = en_s;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready & en_s;
                pc_write   = mem_ready & en_s;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = en_s;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = en_s;
            end
            S_MEMWRITE: begin
                mem_req   = en_s;
                adr_src   = 1'b1;
                mem_write = en_s;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_REG;
                alu_op_s  = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op_s  = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = en_s;
            S_BEQ: begin
                alu_src_a = SRCA_REG;
                alu_op_s  = ALUOP_SUB;
                pc_write  = zero & en_s;
            end
`ifdef RV_JAL_EN
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = en_s;
            end
`endif
            S_TRAP:     mem_req = 1'b0;
            default:    mem_req = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i   (alu_op_s),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .is_rtype_i (op == OP_RTYPE),
        .alu_code_o (alu_code_s)
    );

    assign alu_control = ALU_CTRL_W'(alu_code_s);
    assign illegal     = ill_q;
    assign bus_err     = be_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues the expected
// output vector for each cycle, a negedge monitor pops and compares.
module tb_multicycle_controller;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [6:0]   op;
    logic [2:0]   funct3;
    logic         funct7b5, zero, mem_ready;
    logic         mem_req, mem_write, ir_write, pc_write, reg_write, adr_src;
    logic [1:0]   alu_src_a, alu_src_b, result_src, imm_src;
    logic [W-1:0] alu_control;
    logic         illegal, bus_err;
    logic [19:0]  obs_s;

    typedef struct {
        string       name;
        logic [19:0] val;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_x;
    int   checks = 0;
    int   passes = 0;
    logic ill_e  = 1'b0;
    logic be_e   = 1'b0;

    multicycle_controller #(.ALU_CTRL_W(W), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control),
        .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign obs_s = {mem_req, mem_write, ir_write, pc_write, reg_write, adr_src,
                    alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal, bus_err};

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: imm_of = 2'b01;
            7'b1100011: imm_of = 2'b10;
            7'b1101111: imm_of = 2'b11;
            default:    imm_of = 2'b00;
        endcase
    endfunction

    function automatic logic [19:0] mk(input logic mreq, input logic mw, input logic irw,
                                       input logic pcw, input logic rw, input logic adr,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [3:0] alu);
        mk = {mreq, mw, irw, pcw, rw, adr, a, b, rs, imm_of(op), alu, ill_e, be_e};
    endfunction

    task automatic chk(input string nm, input logic got, input logic exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, got, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic [19:0] e);
        sbq.push_back('{name: nm, val: e});
        @(posedge clk);
        #1;
    endtask

    task automatic f_st(input logic r);
        cyc("FETCH", mk(1'b1, 1'b0, r, r, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 4'd0));
    endtask

    task automatic d_st();
        cyc("DECODE", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 4'd0));
    endtask

    task automatic t_st();
        cyc("TRAP", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0));
    endtask

    task automatic aluwb_st();
        cyc("ALUWB", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0));
    endtask

    task automatic r_instr(input logic [2:0] f3, input logic f7, input logic [3:0] alu);
        op = 7'b0110011; funct3 = f3; funct7b5 = f7;
        f_st(1'b1); d_st();
        cyc("EXEC_R", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, alu));
        aluwb_st();
    endtask

    task automatic i_instr(input logic [2:0] f3, input logic f7, input logic [3:0] alu);
        op = 7'b0010011; funct3 = f3; funct7b5 = f7;
        f_st(1'b1); d_st();
        cyc("EXEC_I", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, alu));
        aluwb_st();
    endtask

    task automatic beq_instr(input logic z);
        op = 7'b1100011; zero = z;
        f_st(1'b1); d_st();
        cyc("BEQ", mk(1'b0, 1'b0, 1'b0, z, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 4'd1));
    endtask

    // Assert reset mid-cycle, check the reset outputs, release after the next edge
    task automatic pulse_reset();
        rst_n = 1'b0;
        ill_e = 1'b0;
        be_e  = 1'b0;
        #1;
        chk("RESET_ILLEGAL", illegal, 1'b0);
        chk("RESET_BUS_ERR", bus_err, 1'b0);
        chk("RESET_STROBES", mem_req | mem_write | ir_write | pc_write | reg_write, 1'b0);
        cyc("RESET", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 4'd0));
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: compare observed outputs against the queued expectation
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_x = sbq.pop_front();
            checks++;
            if (obs_s === mon_x.val) begin
                passes++;
            end else begin
                $display("FAIL %s @%0t: got %b expected %b", mon_x.name, $time, obs_s, mon_x.val);
            end
        end
    end

    // Stimulus sequence
    initial begin
        rst_n = 1'b0; op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        pulse_reset();

        // lw: five cycles, reg_write only in the last
        f_st(1'b1); d_st();
        cyc("MEMADR", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 4'd0));
        cyc("MEMREAD", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0));
        cyc("MEMWB", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 4'd0));

        op = 7'b0100011;
        f_st(1'b1); d_st();
        cyc("MEMADR", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 4'd0));
        cyc("MEMWRITE", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0));

        r_instr(3'b000, 1'b1, 4'd1);
        r_instr(3'b111, 1'b0, 4'd2);
        r_instr(3'b110, 1'b0, 4'd3);
        r_instr(3'b100, 1'b0, 4'd0);
        i_instr(3'b010, 1'b0, 4'd5);
        i_instr(3'b000, 1'b1, 4'd0);
        beq_instr(1'b1);
        beq_instr(1'b0);

        // mem_ready arrives on the last allowed FETCH cycle
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b0;
        repeat (3) f_st(1'b0);
        mem_ready = 1'b1;
        f_st(1'b1); d_st();
        cyc("EXEC_R", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 4'd0));
        aluwb_st();

        // lw with MEMREAD waits; mem_ready low in MEMADR is irrelevant
        op = 7'b0000011;
        f_st(1'b1); d_st();
        mem_ready = 1'b0;
        cyc("MEMADR", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 4'd0));
        repeat (2) cyc("MEMREAD_WAIT", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0));
        mem_ready = 1'b1;
        cyc("MEMREAD", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0));
        cyc("MEMWB", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 4'd0));

        // FETCH timeout -> TRAP with bus_err; mem_ready in TRAP ignored
        mem_ready = 1'b0;
        repeat (4) f_st(1'b0);
        be_e = 1'b1;
        t_st();
        chk("TIMEOUT_BUS_ERR", bus_err, 1'b1);
        mem_ready = 1'b1;
        t_st();
        pulse_reset();

        // illegal opcode
        op = 7'b1111111;
        f_st(1'b1); d_st();
        ill_e = 1'b1;
        t_st(); t_st();
        pulse_reset();

        // reset asserted in the middle of a stalled store
        op = 7'b0100011;
        f_st(1'b1); d_st();
        cyc("MEMADR", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 4'd0));
        mem_ready = 1'b0;
        cyc("MEMWRITE_WAIT", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0));
        pulse_reset();
        mem_ready = 1'b1;

        op = 7'b1101111;
        f_st(1'b1); d_st();
`ifdef RV_JAL_EN
        cyc("JAL", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 4'd0));
        aluwb_st();
        f_st(1'b1);
`else
        ill_e = 1'b1;
        t_st();
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALU_CTRL_W, default 3, alu_control width; SHALL be >=3, upper bits zero.
REQ-002 Parameter MEM_TIMEOUT, default 15, max memory wait cycles before bus error; SHALL be 1..255.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 op  in  7  opcode from instruction register.
REQ-006 funct3  in  3  instruction funct3.
REQ-007 funct7b5  in  1  instruction bit 30.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 mem_ready  in  1  memory completes the current access this cycle.
REQ-010 mem_req  out  1  memory access request.
REQ-011 mem_write, ir_write, pc_write, reg_write  out  1 each  write strobes.
REQ-012 adr_src  out  1  0=PC, 1=ALU result register.
REQ-013 alu_src_a, alu_src_b, result_src, imm_src  out  2 each  datapath selects.
REQ-014 alu_control  out  ALU_CTRL_W  ALU operation.
REQ-015 illegal, bus_err  out  1 each  sticky trap flags.

Function
REQ-016 Moore FSM; outputs decode from state only, except pc_write in BEQ and write strobes qualified by mem_ready.
REQ-017 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BEQ, JAL, TRAP.
REQ-018 FETCH: mem_req=1, adr_src=0, a=00, b=10, alu add, result_src=10; on mem_ready: ir_write=1, pc_write=1, go DECODE; else stay.
REQ-019 DECODE: a=01, b=01, alu add; next by op: 0000011/0100011->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BEQ, 1101111->JAL, other->TRAP.
REQ-020 MEMADR: a=10, b=01, add; lw->MEMREAD, sw->MEMWRITE.
REQ-021 MEMREAD: mem_req=1, adr_src=1; mem_ready->MEMWB. MEMWB: result_src=01, reg_write=1 -> FETCH.
REQ-022 MEMWRITE: mem_req=1, adr_src=1, mem_write=1; mem_ready->FETCH.
REQ-023 EXEC_R: a=10, b=00; EXEC_I: a=10, b=01; both ALU-op decode -> ALUWB. ALUWB: result_src=00, reg_write=1 -> FETCH.
REQ-024 BEQ: a=10, b=00, sub, result_src=00, pc_write=zero -> FETCH.
REQ-025 ALU decode: add 000, sub 001, and 010, or 011, slt 101; funct3 000 with funct7b5=1 and op=0110011 -> sub; unlisted funct3 -> add.
REQ-026 imm_src: I=00, S=01, B=10, J=11, decoded from op every cycle.
REQ-027 Wait counter (8 bit) SHALL clear on entering FETCH/MEMREAD/MEMWRITE, increment each cycle without mem_ready; on reaching MEM_TIMEOUT, go TRAP, set bus_err.
REQ-028 mem_ready in same cycle counter reaches MEM_TIMEOUT: access completes, no bus_err.
REQ-029 TRAP: all strobes 0, mem_req=0; held until reset; illegal set when entered from DECODE.
REQ-030 mem_ready outside request states SHALL be ignored.
REQ-031 Instruction latency with mem_ready tied 1: lw 5, sw/R/I 4, beq 3, jal 4 cycles.

Reset
REQ-032 rst_n low SHALL asynchronously force FETCH, counter 0, illegal=0, bus_err=0, any state including mid-access.
REQ-033 During reset outputs SHALL be FETCH decode with strobes 0; first request on first edge after rst_n release.

Configuration
REQ-034 Macro RV_JAL_EN defined: JAL state present: a=01, b=10, result_src=00, pc_write=1 -> ALUWB (writes PC+4 to rd, PC = ALU target from DECODE).
REQ-035 RV_JAL_EN undefined: no JAL state; op 1101111 -> TRAP with illegal=1.

Structure
REQ-036 Shared package: state enum, opcode constants, ALU code constants, mux-select constants.
REQ-037 Sub-module alu_decoder (combinational ALU-op/funct decode), instantiated once.

Verification
REQ-038 Reset, mem_ready=1, lw (0000011) -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 cycle 5 only.
REQ-039 sub (0110011, f3=000, f7b5=1) -> alu_control=001 in EXEC_R; and f3=111 -> 010.
REQ-040 beq with zero=1 -> pc_write=1 in BEQ; zero=0 -> 0; both back to FETCH cycle 4.
REQ-041 mem_ready held 0 in FETCH, MEM_TIMEOUT=4 -> TRAP after 4 cycles, bus_err=1; mem_ready on 4th cycle -> DECODE, bus_err=0.
REQ-042 op=1111111 -> TRAP, illegal=1, strobes 0; rst_n pulse mid-MEMWRITE -> FETCH, flags cleared.
REQ-043 op=1101111 with and without RV_JAL_EN -> JAL->ALUWB->FETCH vs TRAP/illegal=1.
